dpi_pkt_dispatcher: RTL and testbench

- Front end that drives the bank of per-regex cancid matcher wrappers.
- Takes a byte-wide packet stream tagged with a 16-bit flow key and maps the key to a 6-bit stream id through a 64-entry flow table.
- Sequences load_state, char_in/char_in_vld and eop with the gaps the wrappers' save/restore pipeline requires.
- Collects the wrappers' fired vector into one per-packet result.

---
 rtl/dpi_pkt_dispatcher.sv | 231 +++++++++++++++++++++++
 tb/tb_dpi_pkt_dispatcher.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpi_pkt_dispatcher.sv
// Flow-table lookup and byte sequencer that feeds the per-regex matcher wrappers.
// Optional: define DPI_FLOW_EVICT_EN to evict round-robin on a full-table miss instead of dropping.
module dpi_pkt_dispatcher #(
    parameter int NUM_REGEX = 8,
    parameter int LOAD_GAP  = 2,
    parameter int EOP_GAP   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           pkt_data,
    input  logic [15:0]          pkt_key,
    input  logic                 pkt_sop,
    input  logic                 pkt_eop,
    input  logic                 pkt_vld,
    output logic                 pkt_rdy,
    input  logic [NUM_REGEX-1:0] pkt_enable,
    output logic                 load_state,
    output logic [5:0]           stream_id,
    output logic                 new_stream_id,
    output logic [7:0]           char_in,
    output logic                 char_in_vld,
    output logic                 eop,
    output logic [NUM_REGEX-1:0] enable,
    input  logic [NUM_REGEX-1:0] fired,
    output logic                 res_vld,
    input  logic                 res_rdy,
    output logic [NUM_REGEX-1:0] res_fired,
    output logic [5:0]           res_stream_id,
    output logic                 res_drop
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_LOOKUP = 4'd1;
    localparam logic [3:0] ST_LOAD   = 4'd2;
    localparam logic [3:0] ST_WAIT   = 4'd3;
    localparam logic [3:0] ST_STREAM = 4'd4;
    localparam logic [3:0] ST_DRAIN  = 4'd5;
    localparam logic [3:0] ST_EOP    = 4'd6;
    localparam logic [3:0] ST_RESULT = 4'd7;
    localparam logic [3:0] ST_DROP   = 4'd8;

    logic [3:0]           r_state;
    logic [7:0]           r_cnt;
    logic                 r_first;
    logic                 r_rdy;
    logic [15:0]          r_key;
    logic [NUM_REGEX-1:0] r_en;
    logic [63:0]          r_tbl_vld;
    logic [15:0]          r_tbl_key [0:63];

    logic [63:0] w_hit_vec;
    logic        w_hit;
    logic        w_full;
    logic [5:0]  w_hit_idx;
    logic [5:0]  w_free_idx;
    logic [5:0]  w_alloc_idx;
    logic        w_can_alloc;
    logic        w_tbl_we;
    logic        w_accept;

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_cmp
            assign w_hit_vec[gi] = r_tbl_vld[gi] && (r_tbl_key[gi] == r_key);
        end
    endgenerate

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        w_hit_idx  = 6'd0;
        w_free_idx = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            if (w_hit_vec[i]) w_hit_idx = 6'(i);
            if (!r_tbl_vld[i]) w_free_idx = 6'(i);
        end
    end

    assign w_hit  = |w_hit_vec;
    assign w_full = &r_tbl_vld;

`ifdef DPI_FLOW_EVICT_EN
    logic [5:0] r_evict_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evict_ptr <= 6'd0;
        end else if (r_state == ST_LOOKUP && !w_hit && w_full) begin
            r_evict_ptr <= r_evict_ptr + 6'd1;
        end
    end

    assign w_can_alloc = 1'b1;
    assign w_alloc_idx = w_full ? r_evict_ptr : w_free_idx;
`else
    assign w_can_alloc = !w_full;
    assign w_alloc_idx = w_free_idx;
`endif

    assign w_tbl_we = (r_state == ST_LOOKUP) && !w_hit && w_can_alloc;

    // A sop beat is only taken as the first beat of the current packet; otherwise it is left for IDLE.
    assign pkt_rdy  = r_rdy & (~pkt_sop | r_first);
    assign w_accept = pkt_vld & pkt_rdy;

    always_ff @(posedge clk) begin
        if (w_tbl_we) r_tbl_key[w_alloc_idx] <= r_key;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tbl_vld <= '0;
        end else if (w_tbl_we) begin
            r_tbl_vld[w_alloc_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 8'd0;
            r_first       <= 1'b0;
            r_rdy         <= 1'b0;
            r_key         <= 16'd0;
            r_en          <= '0;
            load_state    <= 1'b0;
            stream_id     <= 6'd0;
            new_stream_id <= 1'b0;
            char_in       <= 8'd0;
            char_in_vld   <= 1'b0;
            eop           <= 1'b0;
            enable        <= '0;
            res_vld       <= 1'b0;
            res_fired     <= '0;
            res_stream_id <= 6'd0;
            res_drop      <= 1'b0;
        end else begin
            load_state  <= 1'b0;
            eop         <= 1'b0;
            char_in_vld <= 1'b0;
            if (w_accept) r_first <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_rdy <= 1'b1;
                    if (pkt_vld && pkt_sop) begin
                        r_key   <= pkt_key;
                        r_en    <= pkt_enable;
                        r_first <= 1'b1;
                        r_rdy   <= 1'b0;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (w_hit || w_can_alloc) begin
                        stream_id     <= w_hit ? w_hit_idx : w_alloc_idx;
                        new_stream_id <= !w_hit;
                        enable        <= r_en;
                        load_state    <= 1'b1;
                        r_state       <= ST_LOAD;
                    end else begin
                        r_rdy   <= 1'b1;
                        r_state <= ST_DROP;
                    end
                end
                ST_LOAD: begin
                    r_cnt   <= 8'(LOAD_GAP - 2);
                    r_rdy   <= (LOAD_GAP == 2);
                    r_state <= ST_WAIT;
                end
                // The last WAIT cycle already accepts, so its byte lands exactly LOAD_GAP cycles after load_state.
                ST_WAIT, ST_STREAM: begin
                    if (r_state == ST_WAIT && r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                        r_rdy <= (r_cnt == 8'd1);
                    end else if (pkt_vld && pkt_sop && !r_first) begin
                        r_cnt   <= 8'(EOP_GAP - 1);
                        r_rdy   <= 1'b0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_state <= ST_STREAM;
                        if (w_accept) begin
                            char_in     <= pkt_data;
                            char_in_vld <= 1'b1;
                            if (pkt_eop) begin
                                r_cnt   <= 8'(EOP_GAP);
                                r_rdy   <= 1'b0;
                                r_state <= ST_DRAIN;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == 8'd0) begin
                        eop     <= 1'b1;
                        r_state <= ST_EOP;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_EOP: begin
                    res_vld       <= 1'b1;
                    res_fired     <= fired & enable;
                    res_stream_id <= stream_id;
                    res_drop      <= 1'b0;
                    stream_id     <= 6'd0;
                    new_stream_id <= 1'b0;
                    enable        <= '0;
                    r_state       <= ST_RESULT;
                end
                ST_DROP: begin
                    if ((pkt_vld && pkt_sop && !r_first) || (w_accept && pkt_eop)) begin
                        r_rdy         <= 1'b0;
                        res_vld       <= 1'b1;
                        res_drop      <= 1'b1;
                        res_fired     <= '0;
                        res_stream_id <= 6'd0;
                        r_state       <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (res_rdy) begin
                        res_vld <= 1'b0;
                        r_rdy   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dpi_pkt_dispatcher.sv
// Directed packets for dpi_pkt_dispatcher with a queue scoreboard on the wrapper-side and result outputs.
// Full-table expectations follow DPI_FLOW_EVICT_EN when the build defines it.
module tb_dpi_pkt_dispatcher;
    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [7:0]    pkt_data = 8'd0;
    logic [15:0]   pkt_key = 16'd0;
    logic          pkt_sop = 1'b0;
    logic          pkt_eop = 1'b0;
    logic          pkt_vld = 1'b0;
    logic          pkt_rdy;
    logic [NR-1:0] pkt_enable = '0;
    logic          load_state;
    logic [5:0]    stream_id;
    logic          new_stream_id;
    logic [7:0]    char_in;
    logic          char_in_vld;
    logic          eop;
    logic [NR-1:0] enable;
    logic [NR-1:0] fired = '0;
    logic          res_vld;
    logic          res_rdy = 1'b1;
    logic [NR-1:0] res_fired;
    logic [5:0]    res_stream_id;
    logic          res_drop;

    dpi_pkt_dispatcher dut (
        .clk(clk), .rst_n(rst_n), .pkt_data(pkt_data), .pkt_key(pkt_key),
        .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy),
        .pkt_enable(pkt_enable), .load_state(load_state), .stream_id(stream_id),
        .new_stream_id(new_stream_id), .char_in(char_in), .char_in_vld(char_in_vld),
        .eop(eop), .enable(enable), .fired(fired), .res_vld(res_vld), .res_rdy(res_rdy),
        .res_fired(res_fired), .res_stream_id(res_stream_id), .res_drop(res_drop)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int eop_seen = 0;
    int eop_exp = 0;
    int exp_gap = 1;
    int load_cyc = 0;
    int last_char_cyc = 0;
    bit first_pend = 1'b0;

    logic [6:0]  q_load [$];
    logic [7:0]  q_char [$];
    logic [14:0] q_res  [$];
    logic [6:0]  lv;
    logic [7:0]  cv;
    logic [14:0] rv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expectations whenever the DUT presents an output event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (load_state) begin
                chk("load_expected", 32'(q_load.size() > 0), 1);
                if (q_load.size() > 0) begin
                    lv = q_load.pop_front();
                    chk("load_id", {25'd0, new_stream_id, stream_id}, {25'd0, lv});
                end
                load_cyc   = cyc;
                first_pend = 1'b1;
            end
            if (char_in_vld) begin
                chk("char_expected", 32'(q_char.size() > 0), 1);
                if (q_char.size() > 0) begin
                    cv = q_char.pop_front();
                    chk("char_byte", {24'd0, char_in}, {24'd0, cv});
                end
                if (first_pend) chk("first_char_gap", cyc - load_cyc, 2);
                else            chk("char_gap", cyc - last_char_cyc, exp_gap);
                first_pend    = 1'b0;
                last_char_cyc = cyc;
            end
            if (eop) begin
                eop_seen++;
                chk("eop_gap", cyc - last_char_cyc, 4);
            end
            if (res_vld && res_rdy) begin
                chk("result_expected", 32'(q_res.size() > 0), 1);
                if (q_res.size() > 0) begin
                    rv = q_res.pop_front();
                    chk("result", {17'd0, res_drop, res_stream_id, res_fired}, {17'd0, rv});
                end
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic s, input logic e);
        int t = 0;
        pkt_data = d;
        pkt_sop  = s;
        pkt_eop  = e;
        pkt_vld  = 1'b1;
        @(negedge clk);
        while (!pkt_rdy && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!pkt_rdy) chk("beat_accept_timeout", {31'd0, pkt_rdy}, 1);
        @(posedge clk);
        #1;
        pkt_vld = 1'b0;
        pkt_sop = 1'b0;
        pkt_eop = 1'b0;
    endtask

    task automatic send_pkt(input logic [15:0] key, input logic [7:0] en, input int n,
                            input logic [7:0] base, input bit toggle, input bit trunc);
        pkt_key    = key;
        pkt_enable = en;
        for (int i = 0; i < n; i++) begin
            if (toggle && i > 0) begin
                @(posedge clk);
                #1;
            end
            send_beat(base + 8'(i), i == 0, (i == n - 1) && !trunc);
        end
    endtask

    task automatic expect_pkt(input logic [5:0] sid, input logic nw, input int n,
                              input logic [7:0] base, input logic [7:0] res_f, input bit drop);
        if (drop) begin
            q_res.push_back({1'b1, 6'd0, 8'd0});
        end else begin
            q_load.push_back({nw, sid});
            for (int i = 0; i < n; i++) q_char.push_back(base + 8'(i));
            eop_exp++;
            q_res.push_back({1'b0, sid, res_f});
        end
    endtask

    task automatic wait_results();
        int t = 0;
        while (q_res.size() != 0 && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk("results_drained", q_res.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {pkt_rdy, load_state, stream_id, new_stream_id, char_in_vld, eop, res_vld, res_drop}, 0);
        chk("reset_data", {char_in, enable, res_fired, res_stream_id}, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Fresh key allocates entry 0, then hit on the same key, then a second key
        fired = 8'h00;
        expect_pkt(6'd0, 1'b1, 5, 8'h11, 8'h00, 1'b0);
        send_pkt(16'h1234, 8'hFF, 5, 8'h11, 1'b0, 1'b0);
        wait_results();
        fired = 8'h05;
        expect_pkt(6'd0, 1'b0, 3, 8'h20, 8'h05, 1'b0);
        send_pkt(16'h1234, 8'h0F, 3, 8'h20, 1'b0, 1'b0);
        wait_results();
        expect_pkt(6'd1, 1'b1, 3, 8'h30, 8'h01, 1'b0);
        send_pkt(16'hBEEF, 8'h01, 3, 8'h30, 1'b0, 1'b0);
        wait_results();

        // Upstream bubbles every other beat, result held back by res_rdy=0
        fired   = 8'hA0;
        exp_gap = 2;
        res_rdy = 1'b0;
        expect_pkt(6'd0, 1'b0, 4, 8'h40, 8'hA0, 1'b0);
        send_pkt(16'h1234, 8'hFF, 4, 8'h40, 1'b1, 1'b0);
        begin
            int t = 0;
            while (!res_vld && t < 100) begin
                @(negedge clk);
                t++;
            end
        end
        exp_gap  = 1;
        pkt_data = 8'hEE;
        pkt_vld  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_res_vld", {31'd0, res_vld}, 1);
            chk("hold_res_data", {17'd0, res_drop, res_stream_id, res_fired}, {17'd0, 1'b0, 6'd0, 8'hA0});
            chk("hold_pkt_rdy", {31'd0, pkt_rdy}, 0);
        end
        @(posedge clk);
        #1;
        res_rdy = 1'b1;
        begin
            int t = 0;
            @(negedge clk);
            while (!pkt_rdy && t < 50) begin
                @(negedge clk);
                t++;
            end
        end
        @(posedge clk);
        #1;
        pkt_vld = 1'b0;
        wait_results();

        // Single-byte packet on a new key
        fired = 8'hFF;
        expect_pkt(6'd2, 1'b1, 1, 8'h50, 8'h03, 1'b0);
        send_pkt(16'h0001, 8'h03, 1, 8'h50, 1'b0, 1'b0);
        wait_results();

        // Truncated packet: the next sop ends it and starts the following packet
        fired = 8'h3C;
        expect_pkt(6'd1, 1'b0, 2, 8'h60, 8'h30, 1'b0);
        send_pkt(16'hBEEF, 8'hF0, 2, 8'h60, 1'b0, 1'b1);
        expect_pkt(6'd0, 1'b0, 3, 8'h70, 8'h0C, 1'b0);
        send_pkt(16'h1234, 8'h0F, 3, 8'h70, 1'b0, 1'b0);
        wait_results();

        // Fill the remaining 61 entries, then a 65th distinct key
        fired = 8'h01;
        for (int i = 3; i < 64; i++) begin
            expect_pkt(6'(i), 1'b1, 1, 8'(i), 8'h01, 1'b0);
            send_pkt(16'h1000 + 16'(i), 8'h01, 1, 8'(i), 1'b0, 1'b0);
        end
        wait_results();
        fired = 8'hFF;
`ifdef DPI_FLOW_EVICT_EN
        expect_pkt(6'd0, 1'b1, 2, 8'h80, 8'hFF, 1'b0);
`else
        expect_pkt(6'd0, 1'b0, 2, 8'h80, 8'h00, 1'b1);
`endif
        send_pkt(16'hF00D, 8'hFF, 2, 8'h80, 1'b0, 1'b0);
        wait_results();

        // Asynchronous reset in the middle of a stream
        expect_pkt(6'd1, 1'b0, 2, 8'h90, 8'h00, 1'b0);
        eop_exp--;
        void'(q_res.pop_back());
        send_pkt(16'hBEEF, 8'hFF, 2, 8'h90, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", {pkt_rdy, load_state, stream_id, new_stream_id, char_in_vld, eop, res_vld, res_drop}, 0);
        chk("async_rst_data", {char_in, enable, res_fired, res_stream_id}, 0);
        chk("pre_reset_chars", q_char.size(), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_pkt(6'd0, 1'b1, 2, 8'hA0, 8'h81, 1'b0);
        send_pkt(16'hBEEF, 8'h81, 2, 8'hA0, 1'b0, 1'b0);
        wait_results();

        repeat (5) @(negedge clk);
        chk("load_queue_empty", q_load.size(), 0);
        chk("char_queue_empty", q_char.size(), 0);
        chk("eop_count", eop_seen, eop_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
